// File: rtl/decode_stage.sv
//==============================================================================
// decode_stage: registered RV32I (+optional M) decode with a decoded-entry FIFO.
// Rev 1.0
//==============================================================================
`default_nettype none

module decode_stage #(
  parameter int BUFFER_DEPTH = 2,
  parameter int ENABLE_M     = 0,
  parameter int PC_WIDTH     = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instruction,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [4:0]          o_source_register1,
  output logic [4:0]          o_source_register2,
  output logic [4:0]          o_destination_register,
  output logic                o_destination_register_write_enable,
  output logic [4:0]          o_alu_operation,
  output logic [31:0]         o_immediate,
  output logic                o_use_immediate,
  output logic                o_use_pc,
  output logic [3:0]          o_branch_condition,
  output logic                o_memory_write_enable,
  output logic                o_memory_read_enable,
  output logic [1:0]          o_memory_size,
  output logic                o_memory_unsigned,
  output logic                o_illegal_instruction
);

  localparam logic [4:0] c_ALU_INVALID = 5'd0,  c_ALU_ADD  = 5'd1,  c_ALU_SUB  = 5'd2,
                         c_ALU_SLL     = 5'd3,  c_ALU_SLT  = 5'd4,  c_ALU_SLTU = 5'd5,
                         c_ALU_XOR     = 5'd6,  c_ALU_SRL  = 5'd7,  c_ALU_SRA  = 5'd8,
                         c_ALU_OR      = 5'd9,  c_ALU_AND  = 5'd10, c_ALU_MUL  = 5'd11;
  localparam logic [3:0] c_BR_NONE = 4'd0, c_BR_EQ  = 4'd1, c_BR_NE  = 4'd2, c_BR_LT = 4'd3,
                         c_BR_GE   = 4'd4, c_BR_LTU = 4'd5, c_BR_GEU = 4'd6, c_BR_JUMP = 4'd7,
                         c_BR_JUMP_REGISTER = 4'd8;
  localparam logic [2:0] c_DEPTH = 3'(BUFFER_DEPTH);
  localparam logic [1:0] c_LAST  = 2'(BUFFER_DEPTH - 1);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                we;
    logic [4:0]          alu;
    logic [31:0]         imm;
    logic                use_imm;
    logic                use_pc;
    logic [3:0]          br;
    logic                mem_we;
    logic                mem_re;
    logic [1:0]          size;
    logic                uns;
    logic                ill;
  } t_entry;

  t_entry     w_dec;
  t_entry     w_head;
  t_entry     r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_push;
  logic       w_pop;
  logic       w_bad;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_funct7 = i_instruction[31:25];
  assign w_imm_i  = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s  = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b  = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                     i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign w_imm_u  = {i_instruction[31:12], 12'b0};
  assign w_imm_j  = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                     i_instruction[20], i_instruction[30:21], 1'b0};

  always_comb begin
    w_dec     = '0;
    w_bad     = 1'b0;
    w_dec.pc  = i_pc;
    w_dec.alu = c_ALU_ADD;
    case (w_opcode)
      7'b0010011: begin // OP-IMM
        w_dec.rs1 = i_instruction[19:15]; w_dec.rd = i_instruction[11:7];
        w_dec.we = 1'b1; w_dec.use_imm = 1'b1; w_dec.imm = w_imm_i;
        case (w_funct3)
          3'b000: w_dec.alu = c_ALU_ADD;
          3'b010: w_dec.alu = c_ALU_SLT;
          3'b011: w_dec.alu = c_ALU_SLTU;
          3'b100: w_dec.alu = c_ALU_XOR;
          3'b110: w_dec.alu = c_ALU_OR;
          3'b111: w_dec.alu = c_ALU_AND;
          3'b001: begin
            w_dec.alu = c_ALU_SLL;
            w_bad     = (w_funct7 != 7'b0000000);
          end
          default: begin
            w_dec.alu = (w_funct7 == 7'b0100000) ? c_ALU_SRA : c_ALU_SRL;
            w_bad     = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
          end
        endcase
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) w_dec.imm = {27'b0, i_instruction[24:20]};
      end
      7'b0110011: begin // OP
        w_dec.rs1 = i_instruction[19:15]; w_dec.rs2 = i_instruction[24:20];
        w_dec.rd  = i_instruction[11:7];  w_dec.we  = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_dec.alu = c_ALU_ADD;
            3'b001:  w_dec.alu = c_ALU_SLL;
            3'b010:  w_dec.alu = c_ALU_SLT;
            3'b011:  w_dec.alu = c_ALU_SLTU;
            3'b100:  w_dec.alu = c_ALU_XOR;
            3'b101:  w_dec.alu = c_ALU_SRL;
            3'b110:  w_dec.alu = c_ALU_OR;
            default: w_dec.alu = c_ALU_AND;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_dec.alu = c_ALU_SUB;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
          w_dec.alu = c_ALU_SRA;
        end else if (w_funct7 == 7'b0000001 && ENABLE_M != 0) begin
          // M ops are encoded contiguously in funct3 order starting at MUL
          w_dec.alu = c_ALU_MUL + {2'b00, w_funct3};
        end else begin
          w_bad = 1'b1;
        end
      end
      7'b0110111: begin // LUI
        w_dec.rd = i_instruction[11:7]; w_dec.we = 1'b1;
        w_dec.use_imm = 1'b1; w_dec.imm = w_imm_u;
      end
      7'b0010111: begin // AUIPC
        w_dec.rd = i_instruction[11:7]; w_dec.we = 1'b1;
        w_dec.use_imm = 1'b1; w_dec.use_pc = 1'b1; w_dec.imm = w_imm_u;
      end
      7'b0000011: begin // LOAD
        w_dec.rs1 = i_instruction[19:15]; w_dec.rd = i_instruction[11:7];
        w_dec.we = 1'b1; w_dec.use_imm = 1'b1; w_dec.imm = w_imm_i; w_dec.mem_re = 1'b1;
        w_dec.size = w_funct3[1:0]; w_dec.uns = w_funct3[2];
        w_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      7'b0100011: begin // STORE
        w_dec.rs1 = i_instruction[19:15]; w_dec.rs2 = i_instruction[24:20];
        w_dec.use_imm = 1'b1; w_dec.imm = w_imm_s; w_dec.mem_we = 1'b1;
        w_dec.size = w_funct3[1:0];
        w_bad = (w_funct3 >= 3'b011);
      end
      7'b1100011: begin // BRANCH
        w_dec.rs1 = i_instruction[19:15]; w_dec.rs2 = i_instruction[24:20];
        w_dec.alu = c_ALU_SUB; w_dec.imm = w_imm_b;
        case (w_funct3)
          3'b000:  w_dec.br = c_BR_EQ;
          3'b001:  w_dec.br = c_BR_NE;
          3'b100:  w_dec.br = c_BR_LT;
          3'b101:  w_dec.br = c_BR_GE;
          3'b110:  w_dec.br = c_BR_LTU;
          3'b111:  w_dec.br = c_BR_GEU;
          default: w_bad    = 1'b1;
        endcase
      end
      7'b1101111: begin // JAL: ALU forms the target pc + imm
        w_dec.rd = i_instruction[11:7]; w_dec.we = 1'b1; w_dec.br = c_BR_JUMP;
        w_dec.imm = w_imm_j; w_dec.use_imm = 1'b1; w_dec.use_pc = 1'b1;
      end
      7'b1100111: begin // JALR
        w_dec.rs1 = i_instruction[19:15]; w_dec.rd = i_instruction[11:7];
        w_dec.we = 1'b1; w_dec.br = c_BR_JUMP_REGISTER;
        w_dec.imm = w_imm_i; w_dec.use_imm = 1'b1;
        w_bad = (w_funct3 != 3'b000);
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec     = '0;
      w_dec.pc  = i_pc;
      w_dec.alu = c_ALU_INVALID;
      w_dec.br  = c_BR_NONE;
      w_dec.ill = 1'b1;
    end
  end

  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == c_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign o_ready = (r_count < c_DEPTH);
  assign o_valid = (r_count != 3'd0);
  assign w_push  = i_valid && o_ready && !i_flush;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count  <= 3'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else if (i_flush) begin
      r_count  <= 3'd0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push && w_pop) r_count <= r_count - 3'd1;
    end
  end

  // Storage needs no reset: every read is gated by o_valid
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign w_head = o_valid ? r_mem[r_rd_ptr] : '0;

  assign o_pc                                = w_head.pc;
  assign o_source_register1                  = w_head.rs1;
  assign o_source_register2                  = w_head.rs2;
  assign o_destination_register              = w_head.rd;
  assign o_destination_register_write_enable = w_head.we;
  assign o_alu_operation                     = w_head.alu;
  assign o_immediate                         = w_head.imm;
  assign o_use_immediate                     = w_head.use_imm;
  assign o_use_pc                            = w_head.use_pc;
  assign o_branch_condition                  = w_head.br;
  assign o_memory_write_enable               = w_head.mem_we;
  assign o_memory_read_enable                = w_head.mem_re;
  assign o_memory_size                       = w_head.size;
  assign o_memory_unsigned                   = w_head.uns;
  assign o_illegal_instruction               = w_head.ill;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//==============================================================================
// tb_decode_stage: directed vector bench for decode_stage (base and M-enabled).
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_decode_stage;

  localparam logic [4:0] ADD = 5'd1, SUB = 5'd2, SLT = 5'd4, SRL = 5'd7, SRA = 5'd8,
                         OR_ = 5'd9, MUL = 5'd11, DIVU = 5'd16;
  localparam logic [3:0] BNONE = 4'd0, BEQ = 4'd1, BLTU = 4'd5, BJ = 4'd7, BJR = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr, pc;

  logic        rdy, vld, we, ui, up, mw, mr, un, il;
  logic [31:0] opc, imm;
  logic [4:0]  rs1, rs2, rd, alu;
  logic [3:0]  br;
  logic [1:0]  sz;

  logic        m_rdy, m_vld, m_we, m_ui, m_up, m_mw, m_mr, m_un, m_il;
  logic [31:0] m_opc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_alu;
  logic [3:0]  m_br;
  logic [1:0]  m_sz;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.BUFFER_DEPTH(2), .ENABLE_M(0), .PC_WIDTH(32)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy),
    .i_instruction(instr), .i_pc(pc), .o_valid(vld), .i_ready(out_ready), .o_pc(opc),
    .o_source_register1(rs1), .o_source_register2(rs2), .o_destination_register(rd),
    .o_destination_register_write_enable(we), .o_alu_operation(alu), .o_immediate(imm),
    .o_use_immediate(ui), .o_use_pc(up), .o_branch_condition(br),
    .o_memory_write_enable(mw), .o_memory_read_enable(mr), .o_memory_size(sz),
    .o_memory_unsigned(un), .o_illegal_instruction(il));

  decode_stage #(.BUFFER_DEPTH(2), .ENABLE_M(1), .PC_WIDTH(32)) u_dut_m (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(m_rdy),
    .i_instruction(instr), .i_pc(pc), .o_valid(m_vld), .i_ready(out_ready), .o_pc(m_opc),
    .o_source_register1(m_rs1), .o_source_register2(m_rs2), .o_destination_register(m_rd),
    .o_destination_register_write_enable(m_we), .o_alu_operation(m_alu), .o_immediate(m_imm),
    .o_use_immediate(m_ui), .o_use_pc(m_up), .o_branch_condition(m_br),
    .o_memory_write_enable(m_mw), .o_memory_read_enable(m_mr), .o_memory_size(m_sz),
    .o_memory_unsigned(m_un), .o_illegal_instruction(m_il));

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic        ui, up;
    logic [3:0]  br;
    logic        mw, mr;
    logic [1:0]  sz;
    logic        un, il;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] i, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                              logic w, logic [4:0] a, logic [31:0] im, logic u, logic p,
                              logic [3:0] b, logic wr, logic rd_, logic [1:0] z, logic uu);
    vec_t v;
    v.instr = i; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.we = w; v.alu = a; v.imm = im;
    v.ui = u; v.up = p; v.br = b; v.mw = wr; v.mr = rd_; v.sz = z; v.un = uu; v.il = 1'b0;
    return v;
  endfunction

  function automatic vec_t ill(logic [31:0] i);
    vec_t v;
    v = mk(i, 0, 0, 0, 0, 5'd0, 0, 0, 0, BNONE, 0, 0, 0, 0);
    v.il = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string t, input vec_t v, input logic [31:0] p);
    cmp({t, " valid"}, 32'(vld), 1);
    cmp({t, " pc"}, opc, p);
    cmp({t, " rs1"}, 32'(rs1), 32'(v.rs1));
    cmp({t, " rs2"}, 32'(rs2), 32'(v.rs2));
    cmp({t, " rd"}, 32'(rd), 32'(v.rd));
    cmp({t, " we"}, 32'(we), 32'(v.we));
    cmp({t, " alu"}, 32'(alu), 32'(v.alu));
    cmp({t, " imm"}, imm, v.imm);
    cmp({t, " use_imm"}, 32'(ui), 32'(v.ui));
    cmp({t, " use_pc"}, 32'(up), 32'(v.up));
    cmp({t, " branch"}, 32'(br), 32'(v.br));
    cmp({t, " mem_we"}, 32'(mw), 32'(v.mw));
    cmp({t, " mem_re"}, 32'(mr), 32'(v.mr));
    cmp({t, " size"}, 32'(sz), 32'(v.sz));
    cmp({t, " unsigned"}, 32'(un), 32'(v.un));
    cmp({t, " illegal"}, 32'(il), 32'(v.il));
  endtask

  task automatic push_idle(input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    in_valid = 1'b1; instr = i; pc = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;

    vecs.push_back(mk(32'h00500093, 0, 0, 1, 1, ADD, 32'd5, 1, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h4030D113, 1, 0, 2, 1, SRA, 32'd3, 1, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0030D113, 1, 0, 2, 1, SRL, 32'd3, 1, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'hFFC12283, 2, 0, 5, 1, ADD, 32'hFFFFFFFC, 1, 0, BNONE, 0, 1, 2'b10, 0));
    vecs.push_back(ill(32'h022081B3));
    vecs.push_back(ill(32'hFFFFFFFF));
    vecs.push_back(mk(32'h402081B3, 1, 2, 3, 1, SUB, 32'd0, 0, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h123453B7, 0, 0, 7, 1, ADD, 32'h12345000, 1, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00001217, 0, 0, 4, 1, ADD, 32'h00001000, 1, 1, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00512423, 2, 5, 0, 0, ADD, 32'd8, 1, 0, BNONE, 1, 0, 2'b10, 0));
    vecs.push_back(mk(32'hFE208CE3, 1, 2, 0, 0, SUB, 32'hFFFFFFF8, 0, 0, BEQ, 0, 0, 0, 0));
    vecs.push_back(mk(32'hFE20ECE3, 1, 2, 0, 0, SUB, 32'hFFFFFFF8, 0, 0, BLTU, 0, 0, 0, 0));
    vecs.push_back(ill(32'hFE20ACE3));
    vecs.push_back(mk(32'h010000EF, 0, 0, 1, 1, ADD, 32'd16, 1, 1, BJ, 0, 0, 0, 0));
    vecs.push_back(mk(32'h00008067, 1, 0, 0, 1, ADD, 32'd0, 1, 0, BJR, 0, 0, 0, 0));
    vecs.push_back(ill(32'h00009067));
    vecs.push_back(ill(32'h40109093));
    vecs.push_back(mk(32'h0000C303, 1, 0, 6, 1, ADD, 32'd0, 1, 0, BNONE, 0, 1, 2'b00, 1));
    vecs.push_back(ill(32'h0000B303));
    vecs.push_back(ill(32'h00513423));
    vecs.push_back(ill(32'h0000000F));
    vecs.push_back(mk(32'hFFF12093, 2, 0, 1, 1, SLT, 32'hFFFFFFFF, 1, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(mk(32'h4020D1B3, 1, 2, 3, 1, SRA, 32'd0, 0, 0, BNONE, 0, 0, 0, 0));
    vecs.push_back(ill(32'h402091B3));
    vecs.push_back(mk(32'h0020E1B3, 1, 2, 3, 1, OR_, 32'd0, 0, 0, BNONE, 0, 0, 0, 0));

    // Reset state
    @(negedge clk);
    cmp("reset valid", 32'(vld), 0);
    cmp("reset ready", 32'(rdy), 1);
    cmp("reset pc", opc, 0);
    cmp("reset imm", imm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-instruction decode table, one push then one pop each
    for (int k = 0; k < vecs.size(); k++) begin
      push_idle(vecs[k].instr, 32'h100 + 32'(k) * 4);
      check_head($sformatf("vec%0d", k), vecs[k], 32'h100 + 32'(k) * 4);
      @(negedge clk);
      cmp($sformatf("vec%0d drained", k), 32'(vld), 0);
      cmp($sformatf("vec%0d empty pc", k), opc, 0);
    end

    // M extension only on the enabled instance
    push_idle(32'h022081B3, 32'h300);
    cmp("mul base illegal", 32'(il), 1);
    cmp("mul base we", 32'(we), 0);
    cmp("mul m alu", 32'(m_alu), 32'(MUL));
    cmp("mul m illegal", 32'(m_il), 0);
    cmp("mul m we", 32'(m_we), 1);
    cmp("mul m rd", 32'(m_rd), 3);
    cmp("mul m rs2", 32'(m_rs2), 2);
    push_idle(32'h0220D1B3, 32'h304);
    cmp("divu m alu", 32'(m_alu), 32'(DIVU));
    cmp("divu base illegal", 32'(il), 1);
    @(negedge clk);

    // Back-pressure: third instruction held upstream, then in-order drain
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500093; pc = 32'h200;
    @(negedge clk);
    cmp("bp ready after 1", 32'(rdy), 1);
    cmp("bp head pc 1", opc, 32'h200);
    instr = 32'h4030D113; pc = 32'h204;
    @(negedge clk);
    cmp("bp ready full", 32'(rdy), 0);
    cmp("bp valid full", 32'(vld), 1);
    cmp("bp head pc 2", opc, 32'h200);
    instr = 32'hFFC12283; pc = 32'h208;
    @(negedge clk);
    cmp("bp ready held", 32'(rdy), 0);
    cmp("bp head stable", opc, 32'h200);
    cmp("bp head rd stable", 32'(rd), 1);
    out_ready = 1'b1;
    @(negedge clk);
    cmp("bp pop1 pc", opc, 32'h204);
    cmp("bp pop1 alu", 32'(alu), 32'(SRA));
    cmp("bp ready after pop", 32'(rdy), 1);
    @(negedge clk);
    cmp("bp pop2 pc", opc, 32'h208);
    cmp("bp pop2 mem_re", 32'(mr), 1);
    in_valid = 1'b0;
    @(negedge clk);
    cmp("bp drained", 32'(vld), 0);

    // Flush beats a same-cycle push
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500093; pc = 32'h400;
    @(negedge clk);
    pc = 32'h404;
    @(negedge clk);
    cmp("flush pre valid", 32'(vld), 1);
    flush = 1'b1; pc = 32'h408;
    @(negedge clk);
    cmp("flush valid", 32'(vld), 0);
    cmp("flush ready", 32'(rdy), 1);
    cmp("flush pc", opc, 0);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("flush dropped", 32'(vld), 0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; pc = 32'h500;
    @(negedge clk);
    pc = 32'h504;
    @(negedge clk);
    in_valid = 1'b0;
    cmp("rst pre ready", 32'(rdy), 0);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst async valid", 32'(vld), 0);
    cmp("rst async ready", 32'(rdy), 1);
    cmp("rst async rd", 32'(rd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cmp("rst after valid", 32'(vld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
